// File: rtl/ddr3_app_tester_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ddr3_test_pkg : shared types and constants for the DDR3 app-port tester
// Rev 1.0
// ---------------------------------------------------------------------------
package ddr3_test_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [2:0] CMD_WRITE       = 3'b000;
    localparam logic [2:0] CMD_READ        = 3'b001;
    localparam int         BURST_ADDR_STEP = 8;
    localparam int         IDX_W           = 9;
    localparam int         LANES           = 8;
    localparam int         DATA_W          = 512;
    localparam int         MASK_W          = 64;

    // Lane k of burst idx: seed + 8*idx + k, wrapping at 64 bits.
    function automatic logic [63:0] lane_value(input logic [63:0]      seed,
                                               input logic [IDX_W-1:0] idx,
                                               input int               lane);
        return seed + (64'(idx) * 64'(BURST_ADDR_STEP)) + 64'(lane);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ddr3_app_tester_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ddr3_app_tester_if : DDR3 controller user (app) command/data interface
// Rev 1.0
// ---------------------------------------------------------------------------
interface ddr3_app_tester_if
    import ddr3_test_pkg::*;
#(
    parameter int ADDR_W = 28
);
    logic [ADDR_W-1:0] app_addr;
    logic [2:0]        app_cmd;
    logic              app_en;
    logic              app_rdy;
    logic [DATA_W-1:0] app_wdf_data;
    logic              app_wdf_wren;
    logic              app_wdf_end;
    logic [MASK_W-1:0] app_wdf_mask;
    logic              app_wdf_rdy;
    logic [DATA_W-1:0] app_rd_data;
    logic              app_rd_data_valid;

    modport master (
        output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren,
               app_wdf_end, app_wdf_mask,
        input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
    );

    modport slave (
        input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren,
               app_wdf_end, app_wdf_mask,
        output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
    );
endinterface
`default_nettype wire

// File: rtl/ddr3_pattern_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ddr3_pattern_gen : combinational (seed, burst index) -> 512-bit pattern
// Rev 1.0
// ---------------------------------------------------------------------------
module ddr3_pattern_gen
    import ddr3_test_pkg::*;
(
    input  wire logic [63:0]       seed_i,
    input  wire logic [IDX_W-1:0]  idx_i,
    output logic      [DATA_W-1:0] pattern_o
);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign pattern_o[64*k +: 64] = lane_value(seed_i, idx_i, k);
    end

endmodule
`default_nettype wire

// File: rtl/ddr3_app_tester.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ddr3_app_tester : writes seed-derived bursts, reads them back and compares
// Rev 1.0
// ---------------------------------------------------------------------------
module ddr3_app_tester
    import ddr3_test_pkg::*;
#(
    parameter int                NUM_BURSTS = 16,
    parameter int                ADDR_W     = 28,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
)
(
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              init_calib_complete,
    input  wire logic              start,
    input  wire logic [63:0]       wr_data,
    ddr3_app_tester_if.master      app,
    output logic                   done,
    output logic                   pass,
    output logic      [15:0]       err_count,
    output logic      [DATA_W-1:0] rd_data
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BURSTS - 1);
    localparam logic [IDX_W-1:0] NUM_IDX  = IDX_W'(NUM_BURSTS);

    state_t              state_q,      state_d;
    logic [63:0]         seed_q,       seed_d;
    logic [IDX_W-1:0]    wr_idx_q,     wr_idx_d;
    logic [IDX_W-1:0]    rd_cmd_idx_q, rd_cmd_idx_d;
    logic [IDX_W-1:0]    rd_idx_q,     rd_idx_d;
    logic                cmd_acc_q,    cmd_acc_d;
    logic                data_acc_q,   data_acc_d;
    logic [15:0]         err_count_q,  err_count_d;
    logic                done_q,       done_d;
    logic                pass_q,       pass_d;
    logic [DATA_W-1:0]   rd_data_q,    rd_data_d;

    logic [DATA_W-1:0]   w_wr_pattern;
    logic [DATA_W-1:0]   w_cmp_pattern;
    logic                w_app_en;
    logic                w_wren;
    logic [IDX_W-1:0]    w_cmd_idx;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_cmd_done;
    logic                w_data_done;
    logic                w_calib_lost;
    logic                w_rd_beat;

    ddr3_pattern_gen u_wr_pattern (
        .seed_i    (seed_q),
        .idx_i     (wr_idx_q),
        .pattern_o (w_wr_pattern)
    );

    ddr3_pattern_gen u_cmp_pattern (
        .seed_i    (seed_q),
        .idx_i     (rd_idx_q),
        .pattern_o (w_cmp_pattern)
    );

    // Outputs are decoded from registered state so an async reset clears them at once.
    assign w_app_en  = ((state_q == WRITE) && !cmd_acc_q) || (state_q == READ);
    assign w_wren    = (state_q == WRITE) && !data_acc_q;
    assign w_cmd_idx = (state_q == READ) ? rd_cmd_idx_q : wr_idx_q;
    assign w_addr    = BASE_ADDR + ADDR_W'(32'(w_cmd_idx) * 32'(BURST_ADDR_STEP));

    assign app.app_en       = w_app_en;
    assign app.app_cmd      = (state_q == READ) ? CMD_READ : CMD_WRITE;
    assign app.app_addr     = w_app_en ? w_addr : '0;
    assign app.app_wdf_wren = w_wren;
    assign app.app_wdf_end  = w_wren;
    assign app.app_wdf_data = w_wren ? w_wr_pattern : '0;
    assign app.app_wdf_mask = '0;

    assign w_cmd_done   = cmd_acc_q  | (w_app_en & app.app_rdy);
    assign w_data_done  = data_acc_q | (w_wren & app.app_wdf_rdy);
    assign w_calib_lost = !init_calib_complete && (state_q inside {WRITE, READ, WAIT});
    assign w_rd_beat    = app.app_rd_data_valid && init_calib_complete &&
                          ((state_q == READ) || (state_q == WAIT)) && (rd_idx_q != NUM_IDX);

    always_comb begin
        state_d      = state_q;
        seed_d       = seed_q;
        wr_idx_d     = wr_idx_q;
        rd_cmd_idx_d = rd_cmd_idx_q;
        rd_idx_d     = rd_idx_q;
        cmd_acc_d    = cmd_acc_q;
        data_acc_d   = data_acc_q;
        err_count_d  = err_count_q;
        done_d       = done_q;
        pass_d       = pass_q;
        rd_data_d    = rd_data_q;

        if (w_rd_beat) begin
            if ((app.app_rd_data != w_cmp_pattern) && (err_count_q != 16'hFFFF)) begin
                err_count_d = err_count_q + 16'd1;
            end
            if (rd_idx_q == '0) begin
                rd_data_d = app.app_rd_data;
            end
            rd_idx_d = rd_idx_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (init_calib_complete) begin
                    seed_d       = wr_data;
                    err_count_d  = '0;
                    wr_idx_d     = '0;
                    rd_cmd_idx_d = '0;
                    rd_idx_d     = '0;
                    cmd_acc_d    = 1'b0;
                    data_acc_d   = 1'b0;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    state_d      = WRITE;
                end
            end
            WRITE: begin
                if (w_cmd_done && w_data_done) begin
                    cmd_acc_d  = 1'b0;
                    data_acc_d = 1'b0;
                    wr_idx_d   = wr_idx_q + 1'b1;
                    if (wr_idx_q == LAST_IDX) begin
                        state_d = READ;
                    end
                end else begin
                    cmd_acc_d  = w_cmd_done;
                    data_acc_d = w_data_done;
                end
            end
            READ: begin
                if (app.app_rdy) begin
                    rd_cmd_idx_d = rd_cmd_idx_q + 1'b1;
                    if (rd_cmd_idx_q == LAST_IDX) begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                // Looking at the post-beat count makes done visible right after the last beat.
                if (rd_idx_d == NUM_IDX) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (w_calib_lost) begin
            state_d    = IDLE;
            cmd_acc_d  = 1'b0;
            data_acc_d = 1'b0;
        end

        if ((state_q != DONE) && (state_d == DONE)) begin
            done_d = 1'b1;
            pass_d = (err_count_d == 16'd0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            seed_q       <= '0;
            wr_idx_q     <= '0;
            rd_cmd_idx_q <= '0;
            rd_idx_q     <= '0;
            cmd_acc_q    <= 1'b0;
            data_acc_q   <= 1'b0;
            err_count_q  <= '0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            seed_q       <= seed_d;
            wr_idx_q     <= wr_idx_d;
            rd_cmd_idx_q <= rd_cmd_idx_d;
            rd_idx_q     <= rd_idx_d;
            cmd_acc_q    <= cmd_acc_d;
            data_acc_q   <= data_acc_d;
            err_count_q  <= err_count_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            rd_data_q    <= rd_data_d;
        end
    end

    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_count_q;
    assign rd_data   = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_ddr3_app_tester.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ddr3_app_tester : controller model + scoreboard bench for ddr3_app_tester
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_ddr3_app_tester;
    import ddr3_test_pkg::*;

    localparam int NB = 4;
    localparam int AW = 28;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         calib = 1'b0;
    logic         start = 1'b0;
    logic [63:0]  wr_data = 64'h0;
    logic         done;
    logic         pass;
    logic [15:0]  err_count;
    logic [511:0] rd_data;

    int checks = 0;
    int failures = 0;

    ddr3_app_tester_if #(.ADDR_W(AW)) app ();

    ddr3_app_tester #(
        .NUM_BURSTS (NB),
        .ADDR_W     (AW),
        .BASE_ADDR  (28'h0)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .init_calib_complete (calib),
        .start               (start),
        .wr_data             (wr_data),
        .app                 (app),
        .done                (done),
        .pass                (pass),
        .err_count           (err_count),
        .rd_data             (rd_data)
    );

    always #5 clk = ~clk;

    // Scoreboard expectations and controller model state
    int           exp_wr_addr[$];
    logic [511:0] exp_wr_data[$];
    int           exp_rd_addr[$];
    logic [511:0] wr_dat_log[$];
    int           wr_cmd_cnt = 0;
    int           rd_cmd_cnt = 0;
    int           pair_addr[$];
    logic [511:0] pair_data[$];
    int           rd_pend[$];
    logic [511:0] mem [int];
    logic [NB-1:0] corrupt_mask = '0;
    bit           bp_mode = 1'b0;
    int           bp_cnt = 0;
    int           stall_viol = 0;
    logic         prev_d_stall = 1'b0;
    logic         prev_c_stall = 1'b0;
    logic [511:0] prev_data = '0;
    logic [AW-1:0] prev_addr = '0;

    function automatic logic [511:0] exp_pattern(input logic [63:0] seed, input int burst);
        logic [511:0] p;
        p = '0;
        for (int k = 0; k < 8; k++) p[64*k +: 64] = seed + 64'(8*burst + k);
        return p;
    endfunction

    // Monitor: sample mid-cycle, score every accepted handshake against expectations.
    always @(negedge clk) begin
        int a;
        int ea;
        logic [511:0] ed;
        if (!rst_n) begin
            prev_d_stall = 1'b0;
            prev_c_stall = 1'b0;
        end else begin
            if (prev_d_stall && (app.app_wdf_data !== prev_data)) stall_viol++;
            if (prev_c_stall && (app.app_addr !== prev_addr)) stall_viol++;
            prev_d_stall = app.app_wdf_wren && !app.app_wdf_rdy;
            prev_c_stall = app.app_en && !app.app_rdy;
            prev_data    = app.app_wdf_data;
            prev_addr    = app.app_addr;
            if (app.app_en && app.app_rdy) begin
                a = int'(app.app_addr);
                if (app.app_cmd == CMD_WRITE) begin
                    wr_cmd_cnt++;
                    pair_addr.push_back(a);
                    checks++;
                    if (exp_wr_addr.size() == 0) begin
                        failures++;
                        $display("FAIL wr_cmd_addr got=%0d expected=<no write>", a);
                    end else begin
                        ea = exp_wr_addr.pop_front();
                        if (a != ea) begin
                            failures++;
                            $display("FAIL wr_cmd_addr got=%0d expected=%0d", a, ea);
                        end
                    end
                end else if (app.app_cmd == CMD_READ) begin
                    rd_cmd_cnt++;
                    rd_pend.push_back(a);
                    checks++;
                    if (exp_rd_addr.size() == 0) begin
                        failures++;
                        $display("FAIL rd_cmd_addr got=%0d expected=<no read>", a);
                    end else begin
                        ea = exp_rd_addr.pop_front();
                        if (a != ea) begin
                            failures++;
                            $display("FAIL rd_cmd_addr got=%0d expected=%0d", a, ea);
                        end
                    end
                end else begin
                    checks++;
                    failures++;
                    $display("FAIL app_cmd got=%b expected=000/001", app.app_cmd);
                end
            end
            if (app.app_wdf_wren && app.app_wdf_rdy) begin
                wr_dat_log.push_back(app.app_wdf_data);
                pair_data.push_back(app.app_wdf_data);
                checks++;
                if (exp_wr_data.size() == 0) begin
                    failures++;
                    $display("FAIL wr_data_beat got=%h expected=<no beat>", app.app_wdf_data);
                end else begin
                    ed = exp_wr_data.pop_front();
                    if (app.app_wdf_data !== ed) begin
                        failures++;
                        $display("FAIL wr_data_beat got=%h expected=%h", app.app_wdf_data, ed);
                    end
                end
            end
            while ((pair_addr.size() > 0) && (pair_data.size() > 0)) begin
                a = pair_addr.pop_front();
                mem[a] = pair_data.pop_front();
            end
        end
    end

    // Controller model drive side: ready pattern and in-order read return.
    always @(posedge clk) begin
        int ra;
        logic [511:0] rdv;
        #1;
        if (!rst_n) bp_cnt = 0;
        if (bp_mode) begin
            app.app_rdy     = (bp_cnt % 6) >= 3;
            app.app_wdf_rdy = (bp_cnt % 6) < 3;
            bp_cnt++;
        end else begin
            app.app_rdy     = 1'b1;
            app.app_wdf_rdy = 1'b1;
        end
        if (rst_n && (rd_pend.size() > 0)) begin
            ra  = rd_pend.pop_front();
            rdv = mem.exists(ra) ? mem[ra] : '0;
            if (corrupt_mask[(ra / 8) % NB]) rdv[0] = ~rdv[0];
            app.app_rd_data       = rdv;
            app.app_rd_data_valid = 1'b1;
        end else begin
            app.app_rd_data       = '0;
            app.app_rd_data_valid = 1'b0;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear_model();
        exp_wr_addr.delete();
        exp_wr_data.delete();
        exp_rd_addr.delete();
        wr_dat_log.delete();
        pair_addr.delete();
        pair_data.delete();
        rd_pend.delete();
        mem.delete();
        wr_cmd_cnt = 0;
        rd_cmd_cnt = 0;
        stall_viol = 0;
    endtask

    task automatic push_expected(input logic [63:0] seed);
        for (int i = 0; i < NB; i++) begin
            exp_wr_addr.push_back(8*i);
            exp_wr_data.push_back(exp_pattern(seed, i));
            exp_rd_addr.push_back(8*i);
        end
    endtask

    task automatic do_reset(input logic [63:0] seed, input logic [NB-1:0] cmask, input bit bp);
        rst_n = 1'b0;
        cyc(2);
        clear_model();
        wr_data      = seed;
        corrupt_mask = cmask;
        bp_mode      = bp;
        push_expected(seed);
        calib = 1'b1;
        rst_n = 1'b1;
    endtask

    task automatic wait_done(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            cyc(1);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        calib = 1'b0;
        cyc(3);
        checks++;
        if ({app.app_en, app.app_wdf_wren, app.app_wdf_end, done, pass} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b expected=00000",
                     {app.app_en, app.app_wdf_wren, app.app_wdf_end, done, pass});
        end
        checks++;
        if (err_count !== 16'h0) begin
            failures++;
            $display("FAIL reset_err_count got=%h expected=0000", err_count);
        end
        checks++;
        if (rd_data !== 512'h0) begin
            failures++;
            $display("FAIL reset_rd_data got=%h expected=0", rd_data);
        end
        checks++;
        if ((app.app_addr !== '0) || (app.app_wdf_data !== '0) || (app.app_wdf_mask !== '0)) begin
            failures++;
            $display("FAIL reset_bus got addr=%h mask=%h data_lane0=%h expected all 0",
                     app.app_addr, app.app_wdf_mask, app.app_wdf_data[63:0]);
        end
        rst_n = 1'b1;
        cyc(5);
        checks++;
        if ((app.app_en !== 1'b0) || (app.app_wdf_wren !== 1'b0)) begin
            failures++;
            $display("FAIL idle_waits_calib got en=%b wren=%b expected 0 0",
                     app.app_en, app.app_wdf_wren);
        end
    endtask

    task automatic test_basic();
        bit ok;
        clear_model();
        push_expected(64'h0);
        cyc(2);
        calib = 1'b1;
        wait_done(200, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL basic_done got=0 expected=1");
        end
        checks++;
        if ((pass !== 1'b1) || (err_count !== 16'h0)) begin
            failures++;
            $display("FAIL basic_result got pass=%b err=%0d expected pass=1 err=0", pass, err_count);
        end
        checks++;
        if ((rd_data[63:0] !== 64'h0) || (rd_data[511:448] !== 64'h7)) begin
            failures++;
            $display("FAIL basic_rd_data got lane0=%h lane7=%h expected 0 and 7",
                     rd_data[63:0], rd_data[511:448]);
        end
        checks++;
        if (wr_dat_log.size() != NB) begin
            failures++;
            $display("FAIL basic_beats got=%0d expected=%0d", wr_dat_log.size(), NB);
        end else begin
            checks++;
            if (wr_dat_log[1][63:0] !== 64'h8) begin
                failures++;
                $display("FAIL basic_burst1_lane0 got=%h expected=8", wr_dat_log[1][63:0]);
            end
        end
        checks++;
        if ((exp_wr_addr.size() + exp_wr_data.size() + exp_rd_addr.size()) != 0) begin
            failures++;
            $display("FAIL basic_sb_left got=%0d expected=0",
                     exp_wr_addr.size() + exp_wr_data.size() + exp_rd_addr.size());
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        do_reset(64'hFFFF_FFFF_FFFF_FFFE, '0, 1'b1);
        wait_done(600, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL bp_done got=0 expected=1");
        end
        checks++;
        if ((wr_cmd_cnt != NB) || (wr_dat_log.size() != NB)) begin
            failures++;
            $display("FAIL bp_counts got cmds=%0d beats=%0d expected %0d %0d",
                     wr_cmd_cnt, wr_dat_log.size(), NB, NB);
        end
        checks++;
        if (stall_viol != 0) begin
            failures++;
            $display("FAIL bp_stall_stable got=%0d changes expected=0", stall_viol);
        end
        if (wr_dat_log.size() > 0) begin
            checks++;
            if (wr_dat_log[0][191:128] !== 64'h0) begin
                failures++;
                $display("FAIL bp_lane2_wrap got=%h expected=0", wr_dat_log[0][191:128]);
            end
        end
        checks++;
        if ((pass !== 1'b1) || ((exp_wr_addr.size() + exp_wr_data.size() + exp_rd_addr.size()) != 0)) begin
            failures++;
            $display("FAIL bp_pass got pass=%b left=%0d expected pass=1 left=0", pass,
                     exp_wr_addr.size() + exp_wr_data.size() + exp_rd_addr.size());
        end
        bp_mode = 1'b0;
    endtask

    task automatic test_corrupt();
        bit ok;
        do_reset(64'h0, 4'b1010, 1'b0);
        wait_done(200, ok);
        checks++;
        if ((!ok) || (pass !== 1'b0) || (err_count !== 16'd2)) begin
            failures++;
            $display("FAIL corrupt_result got done=%b pass=%b err=%0d expected 1 0 2",
                     ok, pass, err_count);
        end
        corrupt_mask = '0;
    endtask

    task automatic test_calib_loss();
        bit ok;
        bit mid;
        do_reset(64'h0, '0, 1'b0);
        mid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            cyc(1);
            if (wr_dat_log.size() >= 2) begin
                mid = 1'b1;
                break;
            end
        end
        checks++;
        if (!mid) begin
            failures++;
            $display("FAIL calib_reach_write got=0 expected=1");
        end
        calib = 1'b0;
        cyc(1);
        checks++;
        if ((app.app_en !== 1'b0) || (app.app_wdf_wren !== 1'b0) || (done !== 1'b0)) begin
            failures++;
            $display("FAIL calib_abort got en=%b wren=%b done=%b expected 0 0 0",
                     app.app_en, app.app_wdf_wren, done);
        end
        checks++;
        if (dut.state_q !== IDLE) begin
            failures++;
            $display("FAIL calib_state got=%0d expected=%0d", dut.state_q, IDLE);
        end
        cyc(5);
        checks++;
        if ((app.app_en !== 1'b0) || (done !== 1'b0)) begin
            failures++;
            $display("FAIL calib_hold got en=%b done=%b expected 0 0", app.app_en, done);
        end
        clear_model();
        push_expected(64'h0);
        calib = 1'b1;
        wait_done(200, ok);
        checks++;
        if ((!ok) || (pass !== 1'b1) || ((exp_wr_addr.size() + exp_wr_data.size() + exp_rd_addr.size()) != 0)) begin
            failures++;
            $display("FAIL calib_rerun got done=%b pass=%b left=%0d expected 1 1 0", ok, pass,
                     exp_wr_addr.size() + exp_wr_data.size() + exp_rd_addr.size());
        end
    endtask

    task automatic test_start_rerun();
        bit ok;
        bit in_read;
        clear_model();
        wr_data = 64'hA5A5_0000_0000_0000;
        push_expected(64'hA5A5_0000_0000_0000);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        in_read = 1'b0;
        for (int i = 0; i < 60; i++) begin
            cyc(1);
            if (rd_cmd_cnt >= 1) begin
                in_read = 1'b1;
                break;
            end
        end
        checks++;
        if (!in_read) begin
            failures++;
            $display("FAIL start_reach_read got=0 expected=1");
        end
        wr_data = 64'h1234;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        wait_done(200, ok);
        checks++;
        if ((!ok) || (pass !== 1'b1) || (rd_data[63:0] !== 64'hA5A5_0000_0000_0000)) begin
            failures++;
            $display("FAIL start_rerun got done=%b pass=%b lane0=%h expected 1 1 a5a5000000000000",
                     ok, pass, rd_data[63:0]);
        end
        cyc(5);
        checks++;
        if ((wr_cmd_cnt != NB) || (rd_cmd_cnt != NB) || (done !== 1'b1)) begin
            failures++;
            $display("FAIL start_ignored got wr=%0d rd=%0d done=%b expected %0d %0d 1",
                     wr_cmd_cnt, rd_cmd_cnt, done, NB, NB);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        bit in_read;
        do_reset(64'h0, '0, 1'b0);
        in_read = 1'b0;
        for (int i = 0; i < 60; i++) begin
            cyc(1);
            if (rd_cmd_cnt >= 2) begin
                in_read = 1'b1;
                break;
            end
        end
        checks++;
        if (!in_read) begin
            failures++;
            $display("FAIL arst_reach_read got=0 expected=1");
        end
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({app.app_en, app.app_wdf_wren, done, pass} !== 4'b0) begin
            failures++;
            $display("FAIL arst_flags got=%b expected=0000",
                     {app.app_en, app.app_wdf_wren, done, pass});
        end
        checks++;
        if ((rd_data !== 512'h0) || (err_count !== 16'h0) || (app.app_addr !== '0)) begin
            failures++;
            $display("FAIL arst_values got rd_lane1=%h err=%0d addr=%h expected 0 0 0",
                     rd_data[127:64], err_count, app.app_addr);
        end
        @(posedge clk);
        #2;
        clear_model();
        push_expected(64'h0);
        rst_n = 1'b1;
        wait_done(200, ok);
        checks++;
        if ((!ok) || (pass !== 1'b1) || ((exp_wr_addr.size() + exp_wr_data.size() + exp_rd_addr.size()) != 0)) begin
            failures++;
            $display("FAIL arst_rerun got done=%b pass=%b left=%0d expected 1 1 0", ok, pass,
                     exp_wr_addr.size() + exp_wr_data.size() + exp_rd_addr.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_corrupt();
        test_calib_loss();
        test_start_rerun();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
